// File: rtl/s_module_pipe.sv
// s_module_pipe: gated-select channel mux followed by a DEPTH-stage registered
// pipeline with valid tracking, stall, flush and a saturating delivered-beat
// counter. Registered building block of the logic-module fabric.
module s_module_pipe #(
  parameter int                 WIDTH    = 5,
  parameter int                 SEL_W    = 2,
  parameter logic [SEL_W-1:0]   SEL_MODE = 2'b10,
  parameter int                 DEPTH    = 2,
  parameter int                 CNT_W    = 8,
  localparam int                NUM_IN   = 2**SEL_W
) (
  input  logic                      clk,
  input  logic                      CLR,
  input  logic [NUM_IN*WIDTH-1:0]   D,
  input  logic [SEL_W-1:0]          SA,
  input  logic [SEL_W-1:0]          SB,
  input  logic                      vin,
  input  logic                      stall,
  input  logic                      flush,
  output logic [WIDTH-1:0]          out,
  output logic                      vout,
  output logic [CNT_W-1:0]          beats
);

  // Counter bump that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) return v;
    else                    return v + CNT_W'(1);
  endfunction

  logic [SEL_W-1:0] sel;
  logic [WIDTH-1:0] mux_data;

  logic [WIDTH-1:0] stage_data_q [DEPTH];
  logic [WIDTH-1:0] stage_data_d [DEPTH];
  logic             vld_q        [DEPTH];
  logic             vld_d        [DEPTH];
  logic [CNT_W-1:0] beats_q;
  logic [CNT_W-1:0] beats_d;

  // Per-bit gated select decode and channel mux (unregistered).
  always_comb begin
    sel      = '0;
    mux_data = '0;
    for (int i = 0; i < SEL_W; i++) begin
      sel[i] = SEL_MODE[i] ? (SA[i] | SB[i]) : (SA[i] & SB[i]);
    end
    for (int k = 0; k < NUM_IN; k++) begin
      if (sel == SEL_W'(k)) mux_data = D[k*WIDTH +: WIDTH];
    end
  end

  // Next-state: flush clears valids only, stall freezes everything,
  // otherwise shift one stage; count beats landing in the last stage.
  always_comb begin
    stage_data_d = stage_data_q;
    vld_d        = vld_q;
    beats_d      = beats_q;
    if (flush) begin
      for (int j = 0; j < DEPTH; j++) vld_d[j] = 1'b0;
    end else if (!stall) begin
      // stage 0 capture boundary
      stage_data_d[0] = mux_data;
      vld_d[0]        = vin;
      // stage j-1 -> j boundaries
      for (int j = 1; j < DEPTH; j++) begin
        stage_data_d[j] = stage_data_q[j-1];
        vld_d[j]        = vld_q[j-1];
      end
      if (vld_d[DEPTH-1]) beats_d = sat_inc(beats_q);
    end
  end

  // State registers; CLR clears data, valids and counter.
  always_ff @(posedge clk) begin
    if (CLR) begin
      for (int j = 0; j < DEPTH; j++) begin
        stage_data_q[j] <= '0;
        vld_q[j]        <= 1'b0;
      end
      beats_q <= '0;
    end else begin
      stage_data_q <= stage_data_d;
      vld_q        <= vld_d;
      beats_q      <= beats_d;
    end
  end

  assign out   = stage_data_q[DEPTH-1];
  assign vout  = vld_q[DEPTH-1];
  assign beats = beats_q;

endmodule

// File: tb/tb_s_module_pipe.sv
// Directed-vector bench for s_module_pipe; a second instance with CNT_W=3
// exercises counter saturation.
module tb_s_module_pipe;

  logic        clk;
  logic        CLR;
  logic [19:0] D;
  logic [1:0]  SA;
  logic [1:0]  SB;
  logic        vin;
  logic        stall;
  logic        flush;
  logic [4:0]  out;
  logic        vout;
  logic [7:0]  beats;
  logic [4:0]  out3;
  logic        vout3;
  logic [2:0]  beats3;

  int n_cmp;
  int n_fail;

  localparam logic [19:0] D_FIX = {5'd3, 5'd2, 5'd1, 5'd0};

  s_module_pipe #(.WIDTH(5), .SEL_W(2), .SEL_MODE(2'b10), .DEPTH(2), .CNT_W(8)) u_dut (
    .clk(clk), .CLR(CLR), .D(D), .SA(SA), .SB(SB), .vin(vin),
    .stall(stall), .flush(flush), .out(out), .vout(vout), .beats(beats)
  );

  s_module_pipe #(.WIDTH(5), .SEL_W(2), .SEL_MODE(2'b10), .DEPTH(2), .CNT_W(3)) u_dut3 (
    .clk(clk), .CLR(CLR), .D(D), .SA(SA), .SB(SB), .vin(vin),
    .stall(stall), .flush(flush), .out(out3), .vout(vout3), .beats(beats3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Select channel k: with SEL_MODE=2'b10, SA=SB=k decodes to k.
  task automatic drive(input logic v, input logic [1:0] ch, input logic st, input logic fl);
    vin   = v;
    SA    = ch;
    SB    = ch;
    stall = st;
    flush = fl;
  endtask

  task automatic do_reset();
    CLR = 1'b1;
    drive(1'b0, 2'd0, 1'b0, 1'b0);
    D = D_FIX;
    tick();
    CLR = 1'b0;
  endtask

  task automatic test_reset();
    CLR = 1'b1;
    drive(1'b1, 2'd1, 1'b0, 1'b0);
    D = 20'($urandom);
    tick();
    tick();
    n_cmp++; if (out !== 5'd0)   begin n_fail++; $display("FAIL reset_out got=%0d want=0", out); end
    n_cmp++; if (vout !== 1'b0)  begin n_fail++; $display("FAIL reset_vout got=%0b want=0", vout); end
    n_cmp++; if (beats !== 8'd0) begin n_fail++; $display("FAIL reset_beats got=%0d want=0", beats); end
    n_cmp++; if (beats3 !== 3'd0) begin n_fail++; $display("FAIL reset_beats3 got=%0d want=0", beats3); end
    CLR = 1'b0;
  endtask

  task automatic test_select();
    do_reset();
    vin = 1'b1; SA = 2'b10; SB = 2'b01; stall = 1'b0; flush = 1'b0;
    tick();
    n_cmp++; if (vout !== 1'b0) begin n_fail++; $display("FAIL sel_e1_vout got=%0b want=0", vout); end
    vin = 1'b0;
    tick();
    n_cmp++; if (out !== 5'd2)   begin n_fail++; $display("FAIL sel_e2_out got=%0d want=2", out); end
    n_cmp++; if (vout !== 1'b1)  begin n_fail++; $display("FAIL sel_e2_vout got=%0b want=1", vout); end
    n_cmp++; if (beats !== 8'd1) begin n_fail++; $display("FAIL sel_e2_beats got=%0d want=1", beats); end
    tick();
    n_cmp++; if (vout !== 1'b0)  begin n_fail++; $display("FAIL sel_e3_vout got=%0b want=0", vout); end
    n_cmp++; if (beats !== 8'd1) begin n_fail++; $display("FAIL sel_e3_beats got=%0d want=1", beats); end
  endtask

  task automatic test_stall();
    do_reset();
    drive(1'b1, 2'd0, 1'b0, 1'b0);
    tick();
    n_cmp++; if (vout !== 1'b0) begin n_fail++; $display("FAIL stall_e1_vout got=%0b want=0", vout); end
    drive(1'b1, 2'd1, 1'b0, 1'b0);
    tick();
    n_cmp++; if (out !== 5'd0 || vout !== 1'b1 || beats !== 8'd1)
      begin n_fail++; $display("FAIL stall_e2 got out=%0d vout=%0b beats=%0d want 0/1/1", out, vout, beats); end
    // Beat for channel 2 offered during stall is dropped.
    drive(1'b1, 2'd2, 1'b1, 1'b0);
    for (int c = 0; c < 3; c++) begin
      tick();
      n_cmp++; if (out !== 5'd0 || vout !== 1'b1 || beats !== 8'd1)
        begin n_fail++; $display("FAIL stall_hold%0d got out=%0d vout=%0b beats=%0d want 0/1/1", c, out, vout, beats); end
    end
    drive(1'b1, 2'd2, 1'b0, 1'b0);
    tick();
    n_cmp++; if (out !== 5'd1 || vout !== 1'b1 || beats !== 8'd2)
      begin n_fail++; $display("FAIL stall_e6 got out=%0d vout=%0b beats=%0d want 1/1/2", out, vout, beats); end
    drive(1'b1, 2'd3, 1'b0, 1'b0);
    tick();
    n_cmp++; if (out !== 5'd2 || vout !== 1'b1 || beats !== 8'd3)
      begin n_fail++; $display("FAIL stall_e7 got out=%0d vout=%0b beats=%0d want 2/1/3", out, vout, beats); end
    drive(1'b0, 2'd3, 1'b0, 1'b0);
    tick();
    n_cmp++; if (out !== 5'd3 || vout !== 1'b1 || beats !== 8'd4)
      begin n_fail++; $display("FAIL stall_e8 got out=%0d vout=%0b beats=%0d want 3/1/4", out, vout, beats); end
    tick();
    n_cmp++; if (vout !== 1'b0 || beats !== 8'd4)
      begin n_fail++; $display("FAIL stall_e9 got vout=%0b beats=%0d want 0/4", vout, beats); end
  endtask

  task automatic test_flush();
    do_reset();
    drive(1'b1, 2'd1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 2'd2, 1'b0, 1'b0);
    tick();
    n_cmp++; if (out !== 5'd1 || vout !== 1'b1 || beats !== 8'd1)
      begin n_fail++; $display("FAIL flush_pre got out=%0d vout=%0b beats=%0d want 1/1/1", out, vout, beats); end
    drive(1'b1, 2'd3, 1'b1, 1'b1);
    tick();
    n_cmp++; if (out !== 5'd1 || vout !== 1'b0 || beats !== 8'd1)
      begin n_fail++; $display("FAIL flush_edge got out=%0d vout=%0b beats=%0d want 1/0/1", out, vout, beats); end
    drive(1'b0, 2'd3, 1'b0, 1'b0);
    tick();
    n_cmp++; if (out !== 5'd2 || vout !== 1'b0 || beats !== 8'd1)
      begin n_fail++; $display("FAIL flush_e4 got out=%0d vout=%0b beats=%0d want 2/0/1", out, vout, beats); end
    tick();
    n_cmp++; if (vout !== 1'b0 || beats !== 8'd1)
      begin n_fail++; $display("FAIL flush_e5 got vout=%0b beats=%0d want 0/1", vout, beats); end
  endtask

  task automatic test_saturate();
    int want;
    do_reset();
    drive(1'b1, 2'd1, 1'b0, 1'b0);
    tick();
    n_cmp++; if (beats3 !== 3'd0) begin n_fail++; $display("FAIL sat_e1 got=%0d want=0", beats3); end
    for (int k = 2; k <= 10; k++) begin
      if (k == 10) vin = 1'b0;
      tick();
      want = (k - 1 > 7) ? 7 : k - 1;
      n_cmp++; if (beats3 !== 3'(want) || vout3 !== 1'b1)
        begin n_fail++; $display("FAIL sat_e%0d got beats3=%0d vout3=%0b want %0d/1", k, beats3, vout3, want); end
    end
    n_cmp++; if (beats !== 8'd9) begin n_fail++; $display("FAIL sat_wide got=%0d want=9", beats); end
    vin = 1'b0;
  endtask

  task automatic test_midreset();
    do_reset();
    drive(1'b1, 2'd1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 2'd2, 1'b0, 1'b0);
    tick();
    CLR = 1'b1;
    drive(1'b1, 2'd2, 1'b0, 1'b0);
    tick();
    n_cmp++; if (out !== 5'd0 || vout !== 1'b0 || beats !== 8'd0)
      begin n_fail++; $display("FAIL mrst_e3 got out=%0d vout=%0b beats=%0d want 0/0/0", out, vout, beats); end
    CLR = 1'b0;
    drive(1'b1, 2'd3, 1'b0, 1'b0);
    tick();
    n_cmp++; if (vout !== 1'b0) begin n_fail++; $display("FAIL mrst_e4_vout got=%0b want=0", vout); end
    drive(1'b0, 2'd3, 1'b0, 1'b0);
    tick();
    n_cmp++; if (out !== 5'd3 || vout !== 1'b1 || beats !== 8'd1)
      begin n_fail++; $display("FAIL mrst_e5 got out=%0d vout=%0b beats=%0d want 3/1/1", out, vout, beats); end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    CLR    = 1'b1;
    D      = '0;
    drive(1'b0, 2'd0, 1'b0, 1'b0);
    test_reset();
    test_select();
    test_stall();
    test_flush();
    test_saturate();
    test_midreset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
